// File: rtl/gdsp_pkg.sv
// Shared types and sizing for the PSRAM arbiter slice: FSM state encoding
// and the default PSRAM word-address / burst-length widths.
package gdsp_pkg;

  localparam int PSRAM_ADDR_W = 21;
  localparam int PSRAM_LEN_W  = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    SKIP      = 2'd3
  } arb_state_t;

endpackage

// File: rtl/psram_arbiter_if.sv
// Signal bundle around psram_arbiter: both requesters, the psram_ctrl command
// path and status. master = requesters/controller side, slave = arbiter side.
interface psram_arbiter_if
  import gdsp_pkg::*;
#(
  parameter int ADDR_W = PSRAM_ADDR_W,
  parameter int LEN_W  = PSRAM_LEN_W
) ();

  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [LEN_W-1:0]  rd_len;
  logic              rd_gnt;
  logic              rd_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [LEN_W-1:0]  wr_len;
  logic              wr_gnt;
  logic              wr_done;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_we;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic [LEN_W-1:0]  mem_cmd_len;
  logic              mem_done;
  logic              busy;
  logic              wr_starved;
  logic [15:0]       rd_count;
  logic [15:0]       wr_count;

  modport master (
    output rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_len, mem_cmd_ready, mem_done,
    input  rd_gnt, rd_done, wr_gnt, wr_done, mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
           mem_cmd_len, busy, wr_starved, rd_count, wr_count
  );

  modport slave (
    input  rd_req, rd_addr, rd_len, wr_req, wr_addr, wr_len, mem_cmd_ready, mem_done,
    output rd_gnt, rd_done, wr_gnt, wr_done, mem_cmd_valid, mem_cmd_we, mem_cmd_addr,
           mem_cmd_len, busy, wr_starved, rd_count, wr_count
  );

endinterface

// File: rtl/psram_arb_stats.sv
// Completed-burst counters for psram_arbiter; the module only exists when
// GDSP_ARB_STATS_EN is defined. Counters wrap 0xFFFF -> 0.
`ifdef GDSP_ARB_STATS_EN
module psram_arb_stats (
  input  logic        clk_sys,
  input  logic        rst,
  input  logic        rd_done,
  input  logic        wr_done,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_comb begin
    rd_cnt_d = rd_cnt_q + {15'd0, rd_done};
    wr_cnt_d = wr_cnt_q + {15'd0, wr_done};
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;

endmodule
`endif

// File: rtl/psram_arbiter.sv
// Two-port PSRAM arbiter: HDMI reads win unless a pending write has been passed
// over MAX_WR_WAIT times. Burst statistics are built only with GDSP_ARB_STATS_EN.
module psram_arbiter
  import gdsp_pkg::*;
#(
  parameter int ADDR_W      = PSRAM_ADDR_W,
  parameter int LEN_W       = PSRAM_LEN_W,
  parameter int MAX_WR_WAIT = 4
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_gnt,
  output logic              rd_done,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              wr_gnt,
  output logic              wr_done,
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_we,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [LEN_W-1:0]  mem_cmd_len,
  input  logic              mem_done,
  output logic              busy,
  output logic              wr_starved,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int            SW         = (MAX_WR_WAIT < 1) ? 1 : $clog2(MAX_WR_WAIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WR_WAIT);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              we_q, we_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rd_done_q, rd_done_d;
  logic              wr_done_q, wr_done_d;
  logic              rest_q, rest_d;
  logic              starved, arb_ok, pick_rd, pick_wr;
  logic [LEN_W-1:0]  win_len;

  assign starved = (starve_q == STARVE_MAX);
  // No arbitration in the done cycle nor the cycle after it, so a requester
  // holding req always sees a quiet IDLE cycle before its next grant.
  assign arb_ok  = !rst && (state_q == IDLE) && !rd_done_q && !wr_done_q && !rest_q;
  assign pick_wr = arb_ok && wr_req && (starved || !rd_req);
  assign pick_rd = arb_ok && rd_req && !pick_wr;
  assign win_len = pick_wr ? wr_len : rd_len;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    we_d      = we_q;
    starve_d  = starve_q;
    rd_done_d = 1'b0;
    wr_done_d = 1'b0;
    rest_d    = rd_done_q | wr_done_q;
    case (state_q)
      IDLE: begin
        if (pick_rd || pick_wr) begin
          addr_d = pick_wr ? wr_addr : rd_addr;
          len_d  = win_len;
          we_d   = pick_wr;
          if (win_len == '0) begin
            // Zero-length bursts complete without touching memory.
            state_d   = SKIP;
            rd_done_d = pick_rd;
            wr_done_d = pick_wr;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE:     if (mem_cmd_ready) state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (mem_done) begin
          state_d   = IDLE;
          rd_done_d = !we_q;
          wr_done_d = we_q;
        end
      end
      SKIP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    if (pick_wr)                          starve_d = '0;
    else if (pick_rd && wr_req && !starved) starve_d = starve_q + SW'(1);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      we_q      <= 1'b0;
      starve_q  <= '0;
      rd_done_q <= 1'b0;
      wr_done_q <= 1'b0;
      rest_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      we_q      <= we_d;
      starve_q  <= starve_d;
      rd_done_q <= rd_done_d;
      wr_done_q <= wr_done_d;
      rest_q    <= rest_d;
    end
  end

  assign rd_gnt        = pick_rd;
  assign wr_gnt        = pick_wr;
  assign rd_done       = rd_done_q;
  assign wr_done       = wr_done_q;
  assign mem_cmd_valid = (state_q == ISSUE);
  assign mem_cmd_we    = we_q;
  assign mem_cmd_addr  = addr_q;
  assign mem_cmd_len   = len_q;
  assign busy          = (state_q != IDLE);
  assign wr_starved    = starved;

`ifdef GDSP_ARB_STATS_EN
  psram_arb_stats u_stats (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .rd_done  (rd_done_q),
    .wr_done  (wr_done_q),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter: read path, starvation hand-over, backpressure,
// zero-length bursts, mid-burst reset and the statistics counters.
module tb_psram_arbiter;
  import gdsp_pkg::*;

  logic clk_sys = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   xfers = 0;
  int   waited;
  int   x0;

  psram_arbiter_if bus ();

  psram_arbiter #(.ADDR_W(PSRAM_ADDR_W), .LEN_W(PSRAM_LEN_W), .MAX_WR_WAIT(4)) dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .rd_req        (bus.rd_req),
    .rd_addr       (bus.rd_addr),
    .rd_len        (bus.rd_len),
    .rd_gnt        (bus.rd_gnt),
    .rd_done       (bus.rd_done),
    .wr_req        (bus.wr_req),
    .wr_addr       (bus.wr_addr),
    .wr_len        (bus.wr_len),
    .wr_gnt        (bus.wr_gnt),
    .wr_done       (bus.wr_done),
    .mem_cmd_valid (bus.mem_cmd_valid),
    .mem_cmd_ready (bus.mem_cmd_ready),
    .mem_cmd_we    (bus.mem_cmd_we),
    .mem_cmd_addr  (bus.mem_cmd_addr),
    .mem_cmd_len   (bus.mem_cmd_len),
    .mem_done      (bus.mem_done),
    .busy          (bus.busy),
    .wr_starved    (bus.wr_starved),
    .rd_count      (bus.rd_count),
    .wr_count      (bus.wr_count)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys)
    if (bus.mem_cmd_valid && bus.mem_cmd_ready) xfers <= xfers + 1;

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Returns with a grant visible (inputs already applied), or after 20 cycles.
  task automatic wait_gnt(output int w);
    w = 0;
    #1;
    while (!(bus.rd_gnt || bus.wr_gnt) && w < 20) begin
      tick();
      w++;
    end
    check1("gnt_seen", bus.rd_gnt || bus.wr_gnt, 1'b1);
  endtask

  // Runs a granted non-zero burst to its done pulse, memory always ready.
  task automatic serve(input logic exp_we, input logic drop);
    tick();
    if (drop) begin
      bus.rd_req = 1'b0;
      bus.wr_req = 1'b0;
    end
    check1("serve_valid", bus.mem_cmd_valid, 1'b1);
    check1("serve_we", bus.mem_cmd_we, exp_we);
    tick();
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    check1("serve_rd_done", bus.rd_done, !exp_we);
    check1("serve_wr_done", bus.wr_done, exp_we);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.rd_req = 1'b1;  bus.rd_addr = 21'h000100;  bus.rd_len = 6'd16;
    bus.wr_req = 1'b0;  bus.wr_addr = '0;          bus.wr_len = '0;
    bus.mem_cmd_ready = 1'b1;
    bus.mem_done = 1'b0;
    tick();
    tick();
    // Reset state, with a request pending to prove grants are held off.
    check1("rst_rd_gnt", bus.rd_gnt, 1'b0);
    check1("rst_valid", bus.mem_cmd_valid, 1'b0);
    check1("rst_busy", bus.busy, 1'b0);
    check1("rst_starved", bus.wr_starved, 1'b0);
    checkn("rst_addr", 32'(bus.mem_cmd_addr), 32'h0);
    checkn("rst_len", 32'(bus.mem_cmd_len), 32'h0);
    check1("rst_we", bus.mem_cmd_we, 1'b0);
    checkn("rst_rd_count", 32'(bus.rd_count), 32'h0);
    bus.rd_req = 1'b0;
    rst = 1'b0;
    tick();

    // Read only: grant same cycle, command next cycle, done one cycle after mem_done.
    bus.rd_req = 1'b1;
    #1;
    check1("rd_gnt_same", bus.rd_gnt, 1'b1);
    check1("rd_valid_early", bus.mem_cmd_valid, 1'b0);
    tick();
    bus.rd_req = 1'b0;
    check1("rd_gnt_pulse", bus.rd_gnt, 1'b0);
    check1("rd_valid", bus.mem_cmd_valid, 1'b1);
    check1("rd_we", bus.mem_cmd_we, 1'b0);
    checkn("rd_addr", 32'(bus.mem_cmd_addr), 32'h100);
    checkn("rd_len", 32'(bus.mem_cmd_len), 32'd16);
    tick();
    check1("rd_valid_drop", bus.mem_cmd_valid, 1'b0);
    check1("rd_busy_wait", bus.busy, 1'b1);
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    check1("rd_done_pulse", bus.rd_done, 1'b1);
    check1("rd_no_wr_done", bus.wr_done, 1'b0);
    tick();
    check1("rd_done_1cyc", bus.rd_done, 1'b0);

    // Both requesting: four reads, then the starved write, then counter clear.
    bus.rd_addr = 21'h000200;  bus.rd_len = 6'd4;
    bus.wr_addr = 21'h000300;  bus.wr_len = 6'd8;
    bus.rd_req = 1'b1;
    bus.wr_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(waited);
      check1($sformatf("arb%0d_rd_gnt", k), bus.rd_gnt, k < 4);
      check1($sformatf("arb%0d_wr_gnt", k), bus.wr_gnt, k == 4);
      check1($sformatf("arb%0d_starved", k), bus.wr_starved, k == 4);
      if (k > 0) checkn($sformatf("arb%0d_gap", k), 32'(waited), 32'd2);
      serve(k == 4, k == 4);
    end
    check1("starve_cleared", bus.wr_starved, 1'b0);

    // Backpressure: ready low for 7 cycles, mem_done in ISSUE ignored.
    bus.mem_cmd_ready = 1'b0;
    bus.rd_addr = 21'h001234;
    bus.rd_len = 6'd33;
    bus.rd_req = 1'b1;
    wait_gnt(waited);
    checkn("bp_gap", 32'(waited), 32'd2);
    x0 = xfers;
    tick();
    bus.rd_req = 1'b0;
    bus.mem_done = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check1($sformatf("bp%0d_valid", i), bus.mem_cmd_valid, 1'b1);
      checkn($sformatf("bp%0d_addr", i), 32'(bus.mem_cmd_addr), 32'h1234);
      checkn($sformatf("bp%0d_len", i), 32'(bus.mem_cmd_len), 32'd33);
      check1($sformatf("bp%0d_rd_done", i), bus.rd_done, 1'b0);
      tick();
    end
    bus.mem_done = 1'b0;
    bus.mem_cmd_ready = 1'b1;
    #1;
    check1("bp_valid_hold", bus.mem_cmd_valid, 1'b1);
    tick();
    check1("bp_valid_off", bus.mem_cmd_valid, 1'b0);
    tick();
    check1("bp_still_wait", bus.rd_done, 1'b0);
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    check1("bp_rd_done", bus.rd_done, 1'b1);
    checkn("bp_one_xfer", 32'(xfers - x0), 32'd1);

    // Zero-length write: done the cycle after grant, no memory command.
    bus.wr_addr = 21'h000055;
    bus.wr_len = 6'd0;
    bus.wr_req = 1'b1;
    x0 = xfers;
    wait_gnt(waited);
    check1("zl_wr_gnt", bus.wr_gnt, 1'b1);
    tick();
    bus.wr_req = 1'b0;
    check1("zl_wr_done", bus.wr_done, 1'b1);
    check1("zl_valid0", bus.mem_cmd_valid, 1'b0);
    check1("zl_busy", bus.busy, 1'b1);
    tick();
    check1("zl_done_1cyc", bus.wr_done, 1'b0);
    check1("zl_valid1", bus.mem_cmd_valid, 1'b0);
    tick();
    checkn("zl_no_xfer", 32'(xfers - x0), 32'd0);

    // Reset while waiting for mem_done: everything drops, no done pulse.
    bus.rd_addr = 21'h000777;
    bus.rd_len = 6'd5;
    bus.rd_req = 1'b1;
    wait_gnt(waited);
    tick();
    bus.rd_req = 1'b0;
    tick();
    check1("mr_busy", bus.busy, 1'b1);
    bus.mem_done = 1'b1;
    bus.rd_addr = 21'h000010;
    bus.rd_len = 6'd2;
    bus.rd_req = 1'b1;
    rst = 1'b1;
    #1;
    check1("mr_valid", bus.mem_cmd_valid, 1'b0);
    check1("mr_busy0", bus.busy, 1'b0);
    check1("mr_rd_done", bus.rd_done, 1'b0);
    check1("mr_rd_gnt", bus.rd_gnt, 1'b0);
    checkn("mr_addr", 32'(bus.mem_cmd_addr), 32'h0);
    checkn("mr_len", 32'(bus.mem_cmd_len), 32'h0);
    check1("mr_we", bus.mem_cmd_we, 1'b0);
    tick();
    check1("mr_no_done", bus.rd_done, 1'b0);
    bus.mem_done = 1'b0;
    rst = 1'b0;
    #1;
    check1("mr_regrant", bus.rd_gnt, 1'b1);
    tick();
    bus.rd_req = 1'b0;
    checkn("mr_new_addr", 32'(bus.mem_cmd_addr), 32'h10);
    check1("mr_new_valid", bus.mem_cmd_valid, 1'b1);
    tick();
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    check1("mr_new_done", bus.rd_done, 1'b1);
    tick();

`ifdef GDSP_ARB_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkn("st_cnt0", 32'(bus.rd_count), 32'h0);
    begin
      int g = 0;
      int cyc = 0;
      bus.rd_len = 6'd0;
      bus.rd_req = 1'b1;
      #1;
      while (g < 65537 && cyc < 250000) begin
        if (bus.rd_gnt) g++;
        tick();
        cyc++;
        if (g == 65537) bus.rd_req = 1'b0;
      end
      bus.rd_req = 1'b0;
      tick();
      tick();
      tick();
      checkn("st_grants", 32'(g), 32'd65537);
      checkn("st_rd_wrap", 32'(bus.rd_count), 32'd1);
      checkn("st_wr_count", 32'(bus.wr_count), 32'd0);
    end
`else
    checkn("nostat_rd", 32'(bus.rd_count), 32'h0);
    checkn("nostat_wr", 32'(bus.wr_count), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
